// File: rtl/apb_sfr_arb_if.sv
// APB bus between the SFR arbiter (master side) and SFR register banks (slave side).
interface apbif #(
   parameter int AW = 12,
   parameter int DW = 32
) ();
   logic            psel;
   logic            penable;
   logic            pwrite;
   logic [AW-1:0]   paddr;
   logic [DW-1:0]   pwdata;
   logic [DW/8-1:0] pstrb;
   logic [2:0]      pprot;
   logic            apbactive;
   logic [DW-1:0]   prdata;
   logic            pready;
   logic            pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb, pprot, apbactive,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot, apbactive,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_sfr_arb.sv
// Round-robin arbiter sharing one APB SFR bus between NREQ single-word requesters,
// sequencing SETUP/ACCESS with wait states and an ACCESS-phase timeout.
module apb_sfr_arb #(
   parameter int NREQ  = 4,
   parameter int AW    = 12,
   parameter int DW    = 32,
   parameter int TOCYC = 255
) (
   input  logic                    pclk,
   input  logic                    resetn,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         reqwr,
   input  logic [NREQ-1:0][AW-1:0] reqaddr,
   input  logic [NREQ-1:0][DW-1:0] reqwdata,
   output logic [NREQ-1:0]         ack,
   output logic                    err,
   output logic [DW-1:0]           rdata,
   output logic [NREQ-1:0]         gnt,
   output logic                    busy,
   apbif.master                    apbm
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TOCYC + 1);
   localparam int SW = DW / 8;
   localparam logic [NREQ-1:0] ONE = 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   state_t          state_q;
   logic [PW-1:0]   ptr_q;
   logic [PW-1:0]   gidx_q;
   logic [CW-1:0]   cnt_q;
   logic [NREQ-1:0] gnt_q;
   logic [NREQ-1:0] ack_q;
   logic            err_q;
   logic            busy_q;
   logic            psel_q;
   logic            penable_q;
   logic            pwrite_q;
   logic [AW-1:0]   paddr_q;
   logic [DW-1:0]   pwdata_q;
   logic [SW-1:0]   pstrb_q;
   logic [DW-1:0]   rdata_q;

   logic            found_d;
   logic [PW-1:0]   widx_d;

   // First pending requester at or above the pointer, wrapping modulo NREQ.
   always_comb begin
      found_d = 1'b0;
      widx_d  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found_d && req[(int'(ptr_q) + i) % NREQ]) begin
            found_d = 1'b1;
            widx_d  = PW'((int'(ptr_q) + i) % NREQ);
         end
      end
   end

   always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         gidx_q    <= '0;
         cnt_q     <= '0;
         gnt_q     <= '0;
         ack_q     <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         rdata_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (found_d) begin
                  state_q  <= SETUP;
                  gidx_q   <= widx_d;
                  gnt_q    <= ONE << widx_d;
                  busy_q   <= 1'b1;
                  psel_q   <= 1'b1;
                  pwrite_q <= reqwr[widx_d];
                  paddr_q  <= reqaddr[widx_d];
                  pwdata_q <= reqwr[widx_d] ? reqwdata[widx_d] : '0;
                  pstrb_q  <= {SW{reqwr[widx_d]}};
               end
            end
            SETUP: begin
               state_q   <= ACCESS;
               penable_q <= 1'b1;
               cnt_q     <= '0;
            end
            ACCESS: begin
               cnt_q <= cnt_q + 1'b1;
               if (apbm.pready) begin
                  if (!pwrite_q) rdata_q <= apbm.prdata;
                  err_q     <= apbm.pslverr;
                  ack_q     <= gnt_q;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  state_q   <= DONE;
               end else if (cnt_q == CW'(TOCYC - 1)) begin
                  // Last permitted ACCESS cycle without pready: terminate with error.
                  err_q     <= 1'b1;
                  ack_q     <= gnt_q;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
               ack_q   <= '0;
               err_q   <= 1'b0;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               ptr_q   <= (int'(gidx_q) == NREQ - 1) ? '0 : gidx_q + 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack            = ack_q;
   assign err            = err_q;
   assign rdata          = rdata_q;
   assign gnt            = gnt_q;
   assign busy           = busy_q;
   assign apbm.psel      = psel_q;
   assign apbm.penable   = penable_q;
   assign apbm.pwrite    = pwrite_q;
   assign apbm.paddr     = paddr_q;
   assign apbm.pwdata    = pwdata_q;
   assign apbm.pstrb     = pstrb_q;
   assign apbm.pprot     = 3'b000;
   assign apbm.apbactive = psel_q;
endmodule

// File: tb/tb_apb_sfr_arb.sv
// Bench for apb_sfr_arb: scripted scenarios plus randomized traffic against a round-robin model.
module tb_apb_sfr_arb;
   localparam int NREQ  = 4;
   localparam int AW    = 12;
   localparam int DW    = 32;
   localparam int TOCYC = 8;
   localparam int SW    = DW / 8;

   logic                    pclk = 1'b0;
   logic                    resetn;
   logic [NREQ-1:0]         req;
   logic [NREQ-1:0]         reqwr;
   logic [NREQ-1:0][AW-1:0] reqaddr;
   logic [NREQ-1:0][DW-1:0] reqwdata;
   logic [NREQ-1:0]         ack;
   logic                    err;
   logic [DW-1:0]           rdata;
   logic [NREQ-1:0]         gnt;
   logic                    busy;

   apbif #(.AW(AW), .DW(DW)) apb ();

   apb_sfr_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .TOCYC(TOCYC)) dut (
      .pclk     (pclk),
      .resetn   (resetn),
      .req      (req),
      .reqwr    (reqwr),
      .reqaddr  (reqaddr),
      .reqwdata (reqwdata),
      .ack      (ack),
      .err      (err),
      .rdata    (rdata),
      .gnt      (gnt),
      .busy     (busy),
      .apbm     (apb)
   );

   always #5 pclk = ~pclk;

   int errs = 0;
   int chks = 0;

   // Reference state: round-robin pointer and last read data returned.
   int            ptr_m;
   logic [DW-1:0] rdata_m;

   // Slave behaviour for the current transfer.
   int            waits_cfg;
   logic          slverr_cfg;
   logic [DW-1:0] prdata_cfg;
   int            acc_cnt = 0;

   // Slave: pready after waits_cfg ACCESS cycles; random noise on the inputs otherwise.
   always @(posedge pclk) begin
      #1;
      if (apb.psel && apb.penable) begin
         apb.pready  = (acc_cnt == waits_cfg);
         apb.pslverr = (acc_cnt == waits_cfg) ? slverr_cfg : 1'($urandom_range(0, 1));
         apb.prdata  = (acc_cnt == waits_cfg) ? prdata_cfg : $urandom;
         acc_cnt++;
      end else begin
         acc_cnt     = 0;
         apb.pready  = 1'($urandom_range(0, 1));
         apb.pslverr = 1'($urandom_range(0, 1));
         apb.prdata  = $urandom;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      int              lat;
      int              nsel;
      int              nen;
      logic [NREQ-1:0] ack;
      logic [NREQ-1:0] gnt;
      logic            err;
      logic [DW-1:0]   rd;
      logic [AW-1:0]   addr;
      logic            wr;
      logic [DW-1:0]   wd;
      logic [SW-1:0]   st;
      logic            stable;
   } xfer_t;

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++)
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic raise(input int r, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      reqwr[r]    = wr;
      reqaddr[r]  = a;
      reqwdata[r] = d;
      req[r]      = 1'b1;
   endtask

   // Steps until an ack appears (or the budget runs out), recording what the bus did.
   task automatic run_xfer(input int budget, output xfer_t x);
      x.lat = 0; x.nsel = 0; x.nen = 0; x.ack = '0; x.gnt = '0; x.err = 1'b0;
      x.rd = '0; x.addr = '0; x.wr = 1'b0; x.wd = '0; x.st = '0; x.stable = 1'b1;
      while (x.lat < budget) begin
         step();
         x.lat++;
         if (x.gnt == '0) x.gnt = gnt;
         if (apb.psel) begin
            if (x.nsel == 0) begin
               x.addr = apb.paddr; x.wr = apb.pwrite; x.wd = apb.pwdata; x.st = apb.pstrb;
            end else if (apb.paddr !== x.addr || apb.pwrite !== x.wr ||
                         apb.pwdata !== x.wd || apb.pstrb !== x.st) begin
               x.stable = 1'b0;
            end
            x.nsel++;
         end
         if (apb.penable) x.nen++;
         if (ack !== '0) begin
            x.ack = ack; x.err = err; x.rd = rdata;
            break;
         end
      end
   endtask

   task automatic test_reset();
      req = '0; reqwr = '0; reqaddr = '0; reqwdata = '0;
      resetn = 1'b0;
      step(); step();
      chks++; if ({apb.psel, apb.penable, apb.apbactive, apb.pwrite} !== 4'b0000) begin errs++;
         $display("FAIL rst_ctl: got %b want 0000", {apb.psel, apb.penable, apb.apbactive, apb.pwrite}); end
      chks++; if (apb.paddr !== '0 || apb.pwdata !== '0) begin errs++;
         $display("FAIL rst_addr_data: got %h/%h want 0/0", apb.paddr, apb.pwdata); end
      chks++; if (apb.pstrb !== '0 || apb.pprot !== 3'b000) begin errs++;
         $display("FAIL rst_strb_prot: got %h/%h want 0/0", apb.pstrb, apb.pprot); end
      chks++; if (ack !== '0 || gnt !== '0) begin errs++;
         $display("FAIL rst_ack_gnt: got %b/%b want 0/0", ack, gnt); end
      chks++; if (err !== 1'b0 || busy !== 1'b0 || rdata !== '0) begin errs++;
         $display("FAIL rst_status: got err=%b busy=%b rdata=%h want 0", err, busy, rdata); end
      resetn = 1'b1;
      step(); step();
      chks++; if (busy !== 1'b0 || apb.psel !== 1'b0) begin errs++;
         $display("FAIL idle_no_req: got busy=%b psel=%b want 0", busy, apb.psel); end
      ptr_m = 0;
      rdata_m = '0;
   endtask

   task automatic test_single_read();
      xfer_t x;
      waits_cfg = 0; slverr_cfg = 1'b0; prdata_cfg = 32'h0000_00a5;
      raise(0, 1'b0, 12'h014, $urandom);
      run_xfer(20, x);
      req[0] = 1'b0;
      chks++; if (x.lat !== 3) begin errs++; $display("FAIL rd_latency: got %0d want 3", x.lat); end
      chks++; if (x.nsel !== 2 || x.nen !== 1) begin errs++;
         $display("FAIL rd_phases: got psel=%0d penable=%0d want 2/1", x.nsel, x.nen); end
      chks++; if (x.ack !== 4'b0001 || x.gnt !== 4'b0001) begin errs++;
         $display("FAIL rd_ack_gnt: got %b/%b want 0001/0001", x.ack, x.gnt); end
      chks++; if (x.rd !== 32'h0000_00a5 || x.err !== 1'b0) begin errs++;
         $display("FAIL rd_data: got %h err=%b want 000000a5 err=0", x.rd, x.err); end
      chks++; if (x.addr !== 12'h014 || x.wr !== 1'b0 || x.wd !== '0 || x.st !== '0 || !x.stable) begin errs++;
         $display("FAIL rd_bus: got a=%h w=%b wd=%h st=%h stable=%b", x.addr, x.wr, x.wd, x.st, x.stable); end
      ptr_m = 1; rdata_m = 32'h0000_00a5;
      step();
      chks++; if (ack !== '0 || gnt !== '0 || busy !== 1'b0) begin errs++;
         $display("FAIL rd_after: got ack=%b gnt=%b busy=%b want 0", ack, gnt, busy); end
   endtask

   task automatic test_wait_write();
      xfer_t x;
      waits_cfg = 3; slverr_cfg = 1'b0; prdata_cfg = $urandom;
      raise(2, 1'b1, 12'h010, 32'h0000_00ff);
      run_xfer(20, x);
      req[2] = 1'b0;
      chks++; if (x.lat !== 6 || x.nen !== 4) begin errs++;
         $display("FAIL wr_latency: got lat=%0d access=%0d want 6/4", x.lat, x.nen); end
      chks++; if (x.ack !== 4'b0100 || x.err !== 1'b0) begin errs++;
         $display("FAIL wr_ack: got %b err=%b want 0100 err=0", x.ack, x.err); end
      chks++; if (x.rd !== rdata_m) begin errs++;
         $display("FAIL wr_rdata_hold: got %h want %h", x.rd, rdata_m); end
      chks++; if (x.wr !== 1'b1 || x.st !== 4'hf || x.wd !== 32'h0000_00ff || x.addr !== 12'h010 || !x.stable) begin errs++;
         $display("FAIL wr_bus: got w=%b st=%h wd=%h a=%h stable=%b", x.wr, x.st, x.wd, x.addr, x.stable); end
      ptr_m = 3;
      step();
   endtask

   task automatic test_contention();
      xfer_t x;
      int g, w, prev;
      logic [NREQ-1:0] eg;
      logic [DW-1:0] prd;
      req = '0;
      resetn = 1'b0; step(); resetn = 1'b1;
      ptr_m = 0; rdata_m = '0; prev = -1;
      for (int r = 0; r < NREQ; r++) raise(r, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
      for (int k = 0; k < 5; k++) begin
         w = $urandom_range(0, 2); prd = $urandom;
         waits_cfg = w; slverr_cfg = 1'b0; prdata_cfg = prd;
         g = pick(req, ptr_m);
         eg = '0; eg[g] = 1'b1;
         run_xfer(30, x);
         chks++; if (x.ack !== eg || x.lat !== 3 + w) begin errs++;
            $display("FAIL rr_order[%0d]: got ack=%b lat=%0d want %b lat=%0d", k, x.ack, x.lat, eg, 3 + w); end
         chks++; if (g == prev || g != (k % NREQ)) begin errs++;
            $display("FAIL rr_sequence[%0d]: model picked %0d want %0d", k, g, k % NREQ); end
         if (!reqwr[g]) rdata_m = prd;
         chks++; if (x.rd !== rdata_m) begin errs++;
            $display("FAIL rr_rdata[%0d]: got %h want %h", k, x.rd, rdata_m); end
         prev = g; ptr_m = (g + 1) % NREQ;
         req[g] = 1'b0;
         step();
         if (k < 4) raise(g, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
      end
      req = '0;
      step();
   endtask

   task automatic test_timeout();
      xfer_t x;
      logic [DW-1:0] prd;
      waits_cfg = 1000; slverr_cfg = 1'b0; prdata_cfg = $urandom;
      raise(1, 1'b0, AW'($urandom), $urandom);
      run_xfer(40, x);
      req[1] = 1'b0;
      chks++; if (x.nen !== TOCYC || x.lat !== TOCYC + 2) begin errs++;
         $display("FAIL to_length: got access=%0d lat=%0d want %0d/%0d", x.nen, x.lat, TOCYC, TOCYC + 2); end
      chks++; if (x.ack !== 4'b0010 || x.err !== 1'b1 || x.rd !== rdata_m) begin errs++;
         $display("FAIL to_result: got ack=%b err=%b rd=%h want 0010 1 %h", x.ack, x.err, x.rd, rdata_m); end
      ptr_m = 2;
      step();
      chks++; if (busy !== 1'b0 || apb.psel !== 1'b0) begin errs++;
         $display("FAIL to_idle: got busy=%b psel=%b want 0", busy, apb.psel); end
      prd = $urandom;
      waits_cfg = 1; prdata_cfg = prd;
      raise(3, 1'b0, AW'($urandom), $urandom);
      run_xfer(20, x);
      req[3] = 1'b0;
      chks++; if (x.ack !== 4'b1000 || x.err !== 1'b0 || x.rd !== prd || x.lat !== 4) begin errs++;
         $display("FAIL to_recover: got ack=%b err=%b rd=%h lat=%0d want 1000 0 %h 4", x.ack, x.err, x.rd, x.lat, prd); end
      rdata_m = prd; ptr_m = 0;
      step();
   endtask

   task automatic test_slverr();
      xfer_t x;
      logic [DW-1:0] prd;
      waits_cfg = $urandom_range(0, 3); slverr_cfg = 1'b1; prdata_cfg = $urandom;
      raise(0, 1'b1, AW'($urandom), $urandom);
      run_xfer(20, x);
      req[0] = 1'b0;
      chks++; if (x.ack !== 4'b0001 || x.err !== 1'b1) begin errs++;
         $display("FAIL se_err: got ack=%b err=%b want 0001 1", x.ack, x.err); end
      ptr_m = 1;
      step();
      chks++; if (err !== 1'b0) begin errs++; $display("FAIL se_err_pulse: got %b want 0", err); end
      prd = $urandom;
      waits_cfg = 0; slverr_cfg = 1'b0; prdata_cfg = prd;
      raise(1, 1'b0, AW'($urandom), $urandom);
      run_xfer(20, x);
      req[1] = 1'b0;
      chks++; if (x.ack !== 4'b0010 || x.err !== 1'b0 || x.rd !== prd) begin errs++;
         $display("FAIL se_next_ok: got ack=%b err=%b rd=%h want 0010 0 %h", x.ack, x.err, x.rd, prd); end
      rdata_m = prd; ptr_m = 2;
      step();
   endtask

   task automatic test_req_drop();
      xfer_t x;
      int w;
      w = $urandom_range(0, 2);
      waits_cfg = w; slverr_cfg = 1'b0; prdata_cfg = $urandom;
      raise(2, 1'b1, AW'($urandom), $urandom);
      step();
      req[2] = 1'b0;
      run_xfer(20, x);
      chks++; if (x.ack !== 4'b0100 || x.lat !== 2 + w) begin errs++;
         $display("FAIL drop_ack: got ack=%b lat=%0d want 0100 lat=%0d", x.ack, x.lat, 2 + w); end
      ptr_m = 3;
      step();
   endtask

   task automatic test_random();
      xfer_t x;
      int g, w;
      logic sv;
      logic [DW-1:0] prd, exp_wd;
      logic [NREQ-1:0] eg;
      for (int r = 0; r < NREQ; r++)
         if ($urandom_range(0, 1) == 1) raise(r, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
      if (req == '0) raise($urandom_range(0, NREQ - 1), 1'b0, AW'($urandom), $urandom);
      for (int it = 0; it < 24; it++) begin
         w = $urandom_range(0, 3); sv = ($urandom_range(0, 3) == 0); prd = $urandom;
         waits_cfg = w; slverr_cfg = sv; prdata_cfg = prd;
         g = pick(req, ptr_m);
         eg = '0; eg[g] = 1'b1;
         exp_wd = reqwr[g] ? reqwdata[g] : '0;
         run_xfer(40, x);
         chks++; if (x.ack !== eg || x.gnt !== eg || x.lat !== 3 + w) begin errs++;
            $display("FAIL rnd_grant[%0d]: got ack=%b gnt=%b lat=%0d want %b lat=%0d", it, x.ack, x.gnt, x.lat, eg, 3 + w); end
         if (!reqwr[g]) rdata_m = prd;
         chks++; if (x.err !== sv || x.rd !== rdata_m) begin errs++;
            $display("FAIL rnd_resp[%0d]: got err=%b rd=%h want err=%b rd=%h", it, x.err, x.rd, sv, rdata_m); end
         chks++; if (x.addr !== reqaddr[g] || x.wr !== reqwr[g] || x.wd !== exp_wd || x.st !== {SW{reqwr[g]}} || !x.stable) begin errs++;
            $display("FAIL rnd_bus[%0d]: got a=%h w=%b wd=%h st=%h stable=%b want a=%h w=%b wd=%h",
                     it, x.addr, x.wr, x.wd, x.st, x.stable, reqaddr[g], reqwr[g], exp_wd); end
         ptr_m = (g + 1) % NREQ;
         req[g] = 1'b0;
         step();
         for (int r = 0; r < NREQ; r++)
            if (!req[r] && $urandom_range(0, 2) == 0) raise(r, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
         if (req == '0) raise($urandom_range(0, NREQ - 1), 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
      end
      req = '0;
      step(); step();
   endtask

   task automatic test_reset_mid();
      xfer_t x;
      logic [DW-1:0] prd;
      waits_cfg = 1000; slverr_cfg = 1'b0; prdata_cfg = $urandom;
      raise(3, 1'b1, AW'($urandom), $urandom);
      raise(1, 1'b0, AW'($urandom), $urandom);
      step(); step(); step();
      chks++; if (apb.psel !== 1'b1 || apb.penable !== 1'b1) begin errs++;
         $display("FAIL mid_in_access: got psel=%b penable=%b want 1/1", apb.psel, apb.penable); end
      resetn = 1'b0;
      #1;
      chks++; if ({apb.psel, apb.penable, busy} !== 3'b000 || gnt !== '0 || ack !== '0) begin errs++;
         $display("FAIL mid_async: got psel=%b pen=%b busy=%b gnt=%b ack=%b want 0",
                  apb.psel, apb.penable, busy, gnt, ack); end
      step();
      chks++; if (ack !== '0 || rdata !== '0) begin errs++;
         $display("FAIL mid_no_ack: got ack=%b rdata=%h want 0/0", ack, rdata); end
      resetn = 1'b1;
      req[3] = 1'b0; req[0] = 1'b0;
      ptr_m = 0; rdata_m = '0;
      prd = $urandom;
      waits_cfg = 0; prdata_cfg = prd;
      run_xfer(20, x);
      req[1] = 1'b0;
      chks++; if (x.ack !== 4'b0010 || x.lat !== 3 || x.rd !== prd || x.err !== 1'b0) begin errs++;
         $display("FAIL mid_regrant: got ack=%b lat=%0d rd=%h err=%b want 0010 3 %h 0", x.ack, x.lat, x.rd, x.err, prd); end
      step();
   endtask

   initial begin
      resetn = 1'b0;
      req = '0; reqwr = '0; reqaddr = '0; reqwdata = '0;
      waits_cfg = 0; slverr_cfg = 1'b0; prdata_cfg = '0;
      ptr_m = 0; rdata_m = '0;
      test_reset();
      test_single_read();
      test_wait_write();
      test_contention();
      test_timeout();
      test_slverr();
      test_req_drop();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end
endmodule
